matrixmult_feeder: RTL and testbench
====================================

// Module: matrixmult_feeder
// PURPOSE
//   Initiator/sequencer for the sequential matrix-vector datapath (multiply unit + per-element accumulator).
//   Holds an NxN matrix and Nx1 pixel vector loaded over a simple write port.
//   On start, streams one operand pair per cycle into the multiplier and drives the accumulator clear/strobe.
//   Collects each finished row sum and emits it on a valid/ready result port.
// PARAMETERS
//   N     4   matrix dimension (rows = cols = vector length); power of two
//   LOG2N 2   log2(N)
//   DW    16  stored element width; operands zero-extended to 32 bits
// PORTS
//   clk          in   1       clock
//   reset        in   1       synchronous, active-high reset
//   cfg_we       in   1       write strobe for operand storage
//   cfg_addr     in   LOG2N*2+1  0..N*N-1 = matrix[row*N+col]; N*N..N*N+N-1 = vector[i]; others ignored
//   cfg_data     in   DW      write data
//   start        in   1       begin a full matrix-vector multiply
//   busy         out  1       1 whenever state != IDLE
//   op_a         out  32      to multiply in1: {0, M[row][col]}
//   op_b         out  32      to multiply in2: {0, V[col]}
//   op_valid     out  1       to multiply inputs_ready
//   acc_in_ready out  1       to accumulator in_ready; op_valid delayed one cycle
//   acc_clear    out  1       OR'd with reset into accumulator reset
//   acc_sum      in   32      accumulator running_sum
//   acc_done     in   1       accumulator done (count == N)
//   out_valid    out  1       result available
//   out_ready    in   1       consumer accepts result
//   out_row      out  LOG2N   row index of out_data
//   out_data     out  32      row result (dot product, mod 2^32)
//   done         out  1       one-cycle pulse after last row accepted
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; row/col counters 0; storage not cleared.
//   Storage: written only in IDLE when cfg_we=1 (incl. the start cycle; value visible to that run). Writes while busy dropped.
//   FSM: IDLE -> CLEAR -> ISSUE -> WAIT -> EMIT -> (CLEAR | IDLE)
//   IDLE:  start=1 -> CLEAR, row=0. start while busy ignored.
//   CLEAR: acc_clear=1 for exactly one cycle; col=0 -> ISSUE.
//   ISSUE: op_valid=1 for exactly N consecutive cycles, col=0..N-1. op_a/op_b are registered, change only here,
//          and are 0 outside ISSUE. After col=N-1 -> WAIT.
//   WAIT:  hold until acc_done=1. Then capture acc_sum -> out_data and row -> out_row -> EMIT.
//          acc_done high on entry to WAIT is impossible after CLEAR; no timeout.
//   EMIT:  out_valid=1; out_data/out_row stable until out_valid&&out_ready.
//          On handshake: out_valid=0. If row==N-1: done=1 next cycle and -> IDLE; else row++ -> CLEAR.
//          out_ready low stalls indefinitely; no new ISSUE starts during a stall.
//   Latency with standard multiply (1 cycle) + accumulator attached, out_ready=1:
//     start sampled at t0 -> acc_clear t1, op_valid t2..t5, acc_in_ready t3..t6, acc_done t7, out_valid t8.
//     Each subsequent row: +8 cycles. done pulses 1 cycle after final handshake.
//   Arithmetic: no internal math. Stored values zero-extended; overflow wraps in the accumulator and passes through unchanged.
//   Reset mid-run: immediate return to IDLE, outputs 0, no done pulse. Partial results discarded.
//   acc_in_ready: always exactly op_valid delayed one cycle, including across reset; forced 0 by reset.
// TESTING
//   1. Load M=[[1,1,2,3],[5,6,7,3],[1,2,3,2],[4,5,3,5]], V=[2,5,3,1], start, out_ready=1
//      -> outputs row0..3 = 16, 64, 23, 47 in order; done one cycle after row3; first out_valid 8 cycles after start.
//   2. M=identity, V=[7,9,11,13] -> out_data 7, 9, 11, 13; op_valid exactly 4 cycles per row; acc_clear once per row.
//   3. All M, V = 0xFFFF -> each row out_data = 0xFFF80004 (wrapped); op_a/op_b = 0x0000FFFF during ISSUE.
//   4. out_ready low 20 cycles on row1 -> out_valid held, out_data=64 stable, no op_valid until handshake;
//      then run completes normally.
//   5. Reset asserted during ISSUE of row2 -> next cycle: busy=0, op_valid=0, out_valid=0, no done pulse.
//      Restart gives test-1 results.
//   6. start and cfg_we while busy -> ignored; storage and results unchanged.
//      cfg_we with start in IDLE -> new value used in that run.

Source files
------------

// File: rtl/matrixmult_feeder.sv
// Sequencer for the matrix-vector datapath: stores M and V, streams operand pairs into the
// multiplier, clears/strobes the accumulator and returns one row sum per valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start, storage writable
// CLEAR | acc_clear asserted for one cycle before a row
// ISSUE | one operand pair per cycle, col 0..N-1
// WAIT  | waiting for the accumulator to report N products summed
// EMIT  | row result held on out_* until accepted
module matrixmult_feeder #(
  parameter int N     = 4,
  parameter int LOG2N = 2,
  parameter int DW    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [LOG2N*2:0]       cfg_addr,
  input  logic [DW-1:0]          cfg_data,
  input  logic                   start,
  output logic                   busy,
  output logic [31:0]            op_a,
  output logic [31:0]            op_b,
  output logic                   op_valid,
  output logic                   acc_in_ready,
  output logic                   acc_clear,
  input  logic [31:0]            acc_sum,
  input  logic                   acc_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LOG2N-1:0]       out_row,
  output logic [31:0]            out_data,
  output logic                   done
);

  localparam int AW = LOG2N*2+1;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N-1);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT, EMIT} state_t;

  state_t          state;
  logic [DW-1:0]   mat [N*N];
  logic [DW-1:0]   vec [N];
  logic [LOG2N-1:0] row;
  logic [LOG2N-1:0] col;
  logic [LOG2N-1:0] col_nxt;
  logic            is_mat;
  logic            is_vec;

  // N is a power of two, so the matrix region is exactly the lower half of the address space
  assign is_mat  = !cfg_addr[AW-1];
  assign is_vec  = cfg_addr[AW-1] && (cfg_addr[AW-2:LOG2N] == '0);
  assign col_nxt = col + 1'b1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE) begin
      if (is_mat)
        mat[cfg_addr[2*LOG2N-1:0]] <= cfg_data;
      else if (is_vec)
        vec[cfg_addr[LOG2N-1:0]] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_valid     <= 1'b0;
      acc_in_ready <= 1'b0;
      acc_clear    <= 1'b0;
      out_valid    <= 1'b0;
      out_row      <= '0;
      out_data     <= '0;
      done         <= 1'b0;
    end else begin
      acc_in_ready <= op_valid;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            row       <= '0;
            acc_clear <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          acc_clear <= 1'b0;
          col       <= '0;
          op_valid  <= 1'b1;
          op_a      <= 32'(mat[{row, LOG2N'(0)}]);
          op_b      <= 32'(vec[0]);
          state     <= ISSUE;
        end
        ISSUE: begin
          if (col == LAST) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            state    <= WAIT;
          end else begin
            col  <= col_nxt;
            op_a <= 32'(mat[{row, col_nxt}]);
            op_b <= 32'(vec[col_nxt]);
          end
        end
        WAIT: begin
          if (acc_done) begin
            out_data  <= acc_sum;
            out_row   <= row;
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (row == LAST) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              row       <= row + 1'b1;
              acc_clear <= 1'b1;
              state     <= CLEAR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrixmult_feeder.sv
// Directed bench for matrixmult_feeder with a behavioural 1-cycle multiplier and accumulator attached.
module tb_matrixmult_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] op_a, op_b;
  logic        op_valid, acc_in_ready, acc_clear;
  logic [31:0] acc_sum;
  logic        acc_done;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_row;
  logic [31:0] out_data;
  logic        done;

  matrixmult_feeder #(.N(4), .LOG2N(2), .DW(16)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .busy(busy), .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .acc_in_ready(acc_in_ready), .acc_clear(acc_clear), .acc_sum(acc_sum), .acc_done(acc_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_data(out_data), .done(done)
  );

  always #5 clk = ~clk;

  // datapath model: registered multiply, accumulator cleared by reset or acc_clear
  logic [31:0] prod;
  logic [2:0]  acc_cnt;
  always_ff @(posedge clk) prod <= op_a * op_b;
  always_ff @(posedge clk) begin
    if (reset || acc_clear) begin
      acc_sum <= '0;
      acc_cnt <= '0;
    end else if (acc_in_ready) begin
      acc_sum <= acc_sum + prod;
      acc_cnt <= acc_cnt + 3'd1;
    end
  end
  assign acc_done = (acc_cnt == 3'd4);

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0, hs_cyc = 0;
  int opv_cnt = 0, clr_cnt = 0, done_cnt = 0, op_leak = 0;
  logic [31:0] res_data[$];
  logic [1:0]  res_row[$];
  logic [15:0] mt[16];
  logic [15:0] vt[4];

  always @(posedge clk) begin
    cyc++;
    if (!reset && out_valid && out_ready) begin
      res_data.push_back(out_data);
      res_row.push_back(out_row);
      hs_cyc = cyc;
    end
    if (op_valid) opv_cnt++;
    if (acc_clear) clr_cnt++;
    if (done) done_cnt++;
    if (!op_valid && (op_a != 0 || op_b != 0)) op_leak++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < 20; i++) begin
      cfg_we   = 1'b1;
      cfg_addr = 5'(i);
      cfg_data = (i < 16) ? mt[i] : vt[i-16];
      step();
    end
    cfg_we = 1'b0;
  endtask

  task automatic clear_log();
    res_data.delete();
    res_row.delete();
    opv_cnt = 0;
    clr_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(n < 400), 32'd1);
  endtask

  task automatic run(input string tag);
    clear_log();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(tag);
  endtask

  task automatic check_results(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e[4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_count"}, 32'(res_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < res_data.size()) begin
        chk($sformatf("%s_data%0d", tag, i), res_data[i], e[i]);
        chk($sformatf("%s_row%0d", tag, i), 32'(res_row[i]), 32'(i));
      end
    end
  endtask

  task automatic load_m1();
    mt = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd6, 16'd7, 16'd3,
           16'd1, 16'd2, 16'd3, 16'd2, 16'd4, 16'd5, 16'd3, 16'd5};
    vt = '{16'd2, 16'd5, 16'd3, 16'd1};
    load_all();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int snap;
    int unstable;

    // reset state
    reset = 1'b1;
    step(); step(); step();
    chk("reset_outputs", {25'd0, busy, op_valid, acc_in_ready, acc_clear, out_valid, done, |{op_a, op_b, out_data}}, 32'd0);
    reset = 1'b0;
    step();

    // 1: reference matrix, latency and done timing
    load_m1();
    clear_log();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_clear_after_start", {30'd0, acc_clear, busy}, 32'd3);
    n = 1;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("t1_first_valid_latency", 32'(n), 32'd8);
    wait_done("t1");
    chk("t1_done_after_last_hs", 32'(cyc - hs_cyc), 32'd0);
    check_results("t1", 32'd16, 32'd64, 32'd23, 32'd47);
    step();
    chk("t1_done_pulse_idle", {30'd0, done, busy}, 32'd0);
    chk("t1_done_count", 32'(done_cnt), 32'd1);

    // 4: consumer stall on row 1
    clear_log();
    out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    chk("t4_row0_data", out_data, 32'd16);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    chk("t4_row1_index", 32'(out_row), 32'd1);
    snap = opv_cnt;
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid !== 1'b1 || out_data !== 32'd64) unstable++;
    end
    chk("t4_stall_stable", 32'(unstable), 32'd0);
    chk("t4_no_issue_in_stall", 32'(opv_cnt - snap), 32'd0);
    out_ready = 1'b1;
    wait_done("t4");
    check_results("t4", 32'd16, 32'd64, 32'd23, 32'd47);

    // 5: reset during ISSUE of row 2, then restart with retained storage
    step();
    clear_log();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(res_data.size() == 2 && op_valid) && n < 100) begin step(); n++; end
    chk("t5_reached_row2_issue", 32'(n < 100), 32'd1);
    reset = 1'b1;
    step();
    chk("t5_after_reset", {27'd0, busy, op_valid, out_valid, acc_in_ready, acc_clear}, 32'd0);
    reset = 1'b0;
    snap = done_cnt;
    for (int i = 0; i < 10; i++) step();
    chk("t5_no_done_pulse", 32'(done_cnt - snap), 32'd0);
    run("t5");
    check_results("t5", 32'd16, 32'd64, 32'd23, 32'd47);

    // 2: identity matrix
    step();
    for (int i = 0; i < 16; i++) mt[i] = (i % 5 == 0) ? 16'd1 : 16'd0;
    vt = '{16'd7, 16'd9, 16'd11, 16'd13};
    load_all();
    run("t2");
    check_results("t2", 32'd7, 32'd9, 32'd11, 32'd13);
    chk("t2_op_valid_cycles", 32'(opv_cnt), 32'd16);
    chk("t2_acc_clear_cycles", 32'(clr_cnt), 32'd4);

    // 3: all-ones operands, wrapped sums
    step();
    for (int i = 0; i < 16; i++) mt[i] = 16'hFFFF;
    vt = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    load_all();
    clear_log();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!op_valid && n < 20) begin step(); n++; end
    chk("t3_op_a", op_a, 32'h0000FFFF);
    chk("t3_op_b", op_b, 32'h0000FFFF);
    wait_done("t3");
    check_results("t3", 32'hFFF80004, 32'hFFF80004, 32'hFFF80004, 32'hFFF80004);

    // 6: writes and start while busy are dropped; write with start in IDLE is used
    step();
    load_m1();
    clear_log();
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    cfg_we = 1'b1;
    cfg_addr = 5'd0;
    cfg_data = 16'd100;
    start = 1'b1;
    step();
    cfg_we = 1'b0;
    start = 1'b0;
    wait_done("t6a");
    check_results("t6a", 32'd16, 32'd64, 32'd23, 32'd47);
    step();
    run("t6b");
    check_results("t6b", 32'd16, 32'd64, 32'd23, 32'd47);
    step();
    clear_log();
    cfg_we = 1'b1;
    cfg_addr = 5'd0;
    cfg_data = 16'd2;
    start = 1'b1;
    step();
    cfg_we = 1'b0;
    start = 1'b0;
    wait_done("t6c");
    check_results("t6c", 32'd18, 32'd64, 32'd23, 32'd47);

    chk("op_zero_outside_issue", 32'(op_leak), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
